spi_slave: RTL and testbench

SPI mode-0 slave front end for the host loader link. Oversamples the external SPI pins (SCLK, MOSI, CS_N, DC) in the system clock domain. Deserializes host bytes into single-cycle byte strobes tagged with the DC level, and serializes a returned byte (RAM read data) onto MISO. Sits directly upstream of the RAM read/write command decoder. It feeds that decoder the byte strobe, data and DC, and accepts back the decoder's "byte ready" pulse together with the read data to transmit.

---
 rtl/spi_slave.sv | 160 ++++++++++++++++
 tb/tb_spi_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI mode-0 slave front end for the host loader link. The SPI pins are
// oversampled in the clk_i domain. Host bytes come out as one-cycle strobes
// tagged with the DC level. A returned byte is shifted out on MISO, MSB first.
//
// Parameters
//   SYNC_STAGES     synchronizer depth on each SPI pin (legal 2..4)
//
// Ports
//   clk_i           system clock, all logic on the rising edge
//   rst_i           synchronous active-high reset
//   spi_sclk_i      SPI clock from host (asynchronous)
//   spi_mosi_i      host-to-slave data (asynchronous)
//   spi_cs_n_i      chip select, active-low (asynchronous)
//   spi_dc_i        data/command line, 0 = command, 1 = data (asynchronous)
//   spi_miso_o      slave-to-host data, driven 0 while deselected
//   spi_byte_vld_o  one-cycle strobe: spi_byte_data_o/dc_o hold a new byte
//   spi_byte_data_o received byte, MSB first on the wire
//   dc_o            DC level sampled on the byte's last SCLK rising edge
//   spi_byte_rdy_i  one-cycle pulse: spi_byte_data_i is the next byte to send
//   spi_byte_data_i transmit byte
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_dc_i,
  output logic       spi_miso_o,
  output logic       spi_byte_vld_o,
  output logic [7:0] spi_byte_data_o,
  output logic       dc_o,
  input  logic       spi_byte_rdy_i,
  input  logic [7:0] spi_byte_data_i
);

  // ---------------------------------------------------------------------------
  // Pin synchronizers. Bit 0 is the first stage; bit SYNC_STAGES-1 is the
  // synchronized value used by the rest of the block.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_n_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic                   sclk_prev;
  logic                   cs_n_prev;

  logic sclk_cur;
  logic mosi_cur;
  logic cs_n_cur;
  logic dc_cur;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update from the same pre-edge values and the synchronizer chain shifts
  // by exactly one stage per clock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_n_sync <= '1;
      dc_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_n_prev <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc_i};
      sclk_prev <= sclk_cur;
      cs_n_prev <= cs_n_cur;
    end
  end

  assign sclk_cur  = sclk_sync[SYNC_STAGES-1];
  assign mosi_cur  = mosi_sync[SYNC_STAGES-1];
  assign cs_n_cur  = cs_n_sync[SYNC_STAGES-1];
  assign dc_cur    = dc_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_cur & ~sclk_prev;
  assign sclk_fall = ~sclk_cur & sclk_prev;
  assign cs_fall   = ~cs_n_cur & cs_n_prev;

  // ---------------------------------------------------------------------------
  // Receive. The byte register and DC are captured on the 8th rising edge;
  // the strobe follows one cycle later. Data is therefore already stable when
  // the strobe is seen and holds until the next byte completes.
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt;
  logic [7:0] rx_sh;
  logic       byte_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt         <= 3'd0;
      rx_sh           <= 8'h00;
      byte_done       <= 1'b0;
      spi_byte_vld_o  <= 1'b0;
      spi_byte_data_o <= 8'h00;
      dc_o            <= 1'b0;
    end else begin
      spi_byte_vld_o <= byte_done;
      byte_done      <= 1'b0;
      if (cs_n_cur) begin
        // Deselected: drop any partial byte and ignore SCLK.
        bit_cnt <= 3'd0;
        rx_sh   <= 8'h00;
      end else if (sclk_rise) begin
        rx_sh   <= {rx_sh[6:0], mosi_cur};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done       <= 1'b1;
          spi_byte_data_o <= {rx_sh[6:0], mosi_cur};
          dc_o            <= dc_cur;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit. tx_sh reloads at select and at each byte boundary (the SCLK
  // fall after the 8th rise, where bit_cnt has wrapped to 0). A ready pulse
  // on the same cycle as a reload wins over the older tx_buf contents.
  // ---------------------------------------------------------------------------
  logic [7:0] tx_buf;
  logic [7:0] tx_sh;
  logic [7:0] tx_load_val;
  logic       tx_load;
  logic       tx_shift;

  assign tx_load_val = spi_byte_rdy_i ? spi_byte_data_i : tx_buf;
  assign tx_load     = cs_fall | (sclk_fall & ~cs_n_cur & (bit_cnt == 3'd0));
  assign tx_shift    = sclk_fall & ~cs_n_cur;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_buf     <= 8'h00;
      tx_sh      <= 8'h00;
      spi_miso_o <= 1'b0;
    end else begin
      if (spi_byte_rdy_i) begin
        tx_buf <= spi_byte_data_i;
      end
      if (tx_load) begin
        tx_sh <= tx_load_val;
      end else if (tx_shift) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
      // Registered so MISO changes SYNC_STAGES + 2 cycles after the pin fall.
      spi_miso_o <= ~cs_n_cur & tx_sh[7];
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Directed bench for spi_slave. A host task bit-bangs SPI mode 0 with SCLK
// half-periods of HALF clk cycles and samples MISO on each rising edge it
// drives. A monitor records every strobe with its cycle stamp so byte data,
// DC and latency can be checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_dc   = 1'b0;
  logic       byte_rdy = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       spi_miso;
  logic       byte_vld;
  logic [7:0] byte_data;
  logic       dc_out;

  spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .spi_sclk_i      (spi_sclk),
    .spi_mosi_i      (spi_mosi),
    .spi_cs_n_i      (spi_cs_n),
    .spi_dc_i        (spi_dc),
    .spi_miso_o      (spi_miso),
    .spi_byte_vld_o  (byte_vld),
    .spi_byte_data_o (byte_data),
    .dc_o            (dc_out),
    .spi_byte_rdy_i  (byte_rdy),
    .spi_byte_data_i (tx_data)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         cyc_at;
  } strobe_t;

  strobe_t strobe_q[$];
  int      wide_cnt = 0;
  logic    vld_prev = 1'b0;

  always @(negedge clk_i) begin
    if (byte_vld === 1'b1) begin
      strobe_q.push_back('{data: byte_data, dc: dc_out, cyc_at: cyc});
      if (vld_prev === 1'b1) wide_cnt++;
    end
    vld_prev = byte_vld;
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_rise = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Sends the top n bits of b MSB first; got collects MISO at each rise.
  // With bypass set, a ready pulse is placed on the cycle the boundary
  // SCLK fall is detected (SYNC_STAGES clocks after the pin fall).
  task automatic send_bits(input logic [7:0] b, input int n, input bit bypass,
                           input logic [7:0] bval, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      wait_cyc(HALF);
      spi_sclk  = 1'b1;
      last_rise = cyc;
      got       = {got[6:0], spi_miso};
      wait_cyc(HALF);
      spi_sclk = 1'b0;
    end
    if (bypass) begin
      wait_cyc(SYNC_STAGES);
      byte_rdy = 1'b1;
      tx_data  = bval;
      wait_cyc(1);
      byte_rdy = 1'b0;
      tx_data  = 8'hFF;
      wait_cyc(HALF - SYNC_STAGES - 1);
    end else begin
      wait_cyc(HALF);
    end
  endtask

  task automatic expect_strobe(input string tag, input logic [7:0] d, input logic dcv);
    strobe_t s;
    check({tag, ".count"}, strobe_q.size(), 1);
    if (strobe_q.size() > 0) begin
      s = strobe_q.pop_front();
      check({tag, ".data"}, s.data, d);
      check({tag, ".dc"}, s.dc, dcv);
      check({tag, ".latency"}, s.cyc_at - last_rise, SYNC_STAGES + 2);
    end
    strobe_q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] got;

  initial begin
    // Reset with the pins toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      spi_sclk = ~spi_sclk;
      spi_mosi = ~spi_mosi;
      spi_cs_n = ~spi_cs_n;
      spi_dc   = ~spi_dc;
    end
    @(negedge clk_i);
    check("rst.miso", spi_miso, 0);
    check("rst.vld", byte_vld, 0);
    check("rst.data", byte_data, 8'h00);
    check("rst.dc", dc_out, 0);
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    spi_dc   = 1'b0;
    rst_i    = 1'b0;
    wait_cyc(5);
    check("post_rst.strobes", strobe_q.size(), 0);
    check("post_rst.vld", byte_vld, 0);
    check("post_rst.miso", spi_miso, 0);

    // Receive two bytes with different DC levels.
    spi_cs_n = 1'b0;
    wait_cyc(6);
    spi_dc = 1'b0;
    send_bits(8'h2C, 8, 1'b0, 8'h00, got);
    expect_strobe("rx_2c", 8'h2C, 1'b0);
    spi_dc = 1'b1;
    send_bits(8'hA5, 8, 1'b0, 8'h00, got);
    expect_strobe("rx_a5", 8'hA5, 1'b1);
    wait_cyc(10);
    check("rx_a5.hold", byte_data, 8'hA5);
    spi_cs_n = 1'b1;
    spi_dc   = 1'b0;
    wait_cyc(6);

    // Aborted partial byte, then a full byte after re-select.
    spi_cs_n = 1'b0;
    wait_cyc(6);
    send_bits(8'b1011_0000, 5, 1'b0, 8'h00, got);
    spi_cs_n = 1'b1;
    wait_cyc(8);
    check("abort.strobes", strobe_q.size(), 0);
    spi_cs_n = 1'b0;
    wait_cyc(6);
    send_bits(8'h3C, 8, 1'b0, 8'h00, got);
    expect_strobe("abort_3c", 8'h3C, 1'b0);
    spi_cs_n = 1'b1;
    wait_cyc(6);

    // Transmit: load 0x5A while idle, then read it twice; bypass 0xC3 at the
    // second byte's boundary and read it on the third.
    check("idle.miso", spi_miso, 0);
    byte_rdy = 1'b1;
    tx_data  = 8'h5A;
    wait_cyc(1);
    byte_rdy = 1'b0;
    tx_data  = 8'hFF;
    wait_cyc(2);
    spi_cs_n = 1'b0;
    wait_cyc(6);
    send_bits(8'h11, 8, 1'b0, 8'h00, got);
    check("tx.first", got, 8'h5A);
    expect_strobe("tx_rx_11", 8'h11, 1'b0);
    send_bits(8'h22, 8, 1'b1, 8'hC3, got);
    check("tx.repeat", got, 8'h5A);
    expect_strobe("tx_rx_22", 8'h22, 1'b0);
    send_bits(8'h33, 8, 1'b0, 8'h00, got);
    check("tx.bypass", got, 8'hC3);
    expect_strobe("tx_rx_33", 8'h33, 1'b0);
    spi_cs_n = 1'b1;
    wait_cyc(6);

    // Reset in the middle of bit 4 of a byte.
    spi_cs_n = 1'b0;
    wait_cyc(6);
    send_bits(8'hF0, 4, 1'b0, 8'h00, got);
    spi_mosi = 1'b1;
    wait_cyc(4);
    spi_sclk = 1'b1;
    wait_cyc(4);
    rst_i = 1'b1;
    wait_cyc(2);
    check("midrst.data", byte_data, 8'h00);
    check("midrst.vld", byte_vld, 0);
    check("midrst.miso", spi_miso, 0);
    rst_i    = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    wait_cyc(8);
    check("midrst.strobes", strobe_q.size(), 0);
    spi_cs_n = 1'b0;
    wait_cyc(6);
    send_bits(8'h81, 8, 1'b0, 8'h00, got);
    expect_strobe("midrst_81", 8'h81, 1'b0);
    spi_cs_n = 1'b1;
    wait_cyc(6);

    check("strobe.width", wide_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
